// File: rtl/wb_arbiter_pkg.sv
// Shared types for the regfile write-back arbiter: result source encoding and
// a helper that maps a source to its grant bit.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_src_e;

  function automatic logic [2:0] src_onehot(wb_src_e src);
    logic [2:0] oh;
    oh = 3'b000;
    oh[src] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_arbiter_starve_counter.sv
// Saturating wait counter: counts cycles a requester is valid but not granted,
// clears on grant or when the requester drops valid.
module starve_counter #(
  parameter int unsigned LIMIT = 8,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic             ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             starved_o
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (!valid_i || ready_i) begin
      count_d = '0;
    end else if (count_q != Limit) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign starved_o = (count_q == Limit);

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: ALU has fixed priority, LSU/MDU share the rest
// round-robin, and a starved LSU/MDU preempts the ALU. Output is registered.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [4:0]            lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [4:0]            mdu_rd,
  input  logic [DATA_WIDTH-1:0] mdu_data,
  output logic                  w_ena,
  output logic [4:0]            w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [2:0]            grant_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic                  valid;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  wb_req_t alu_req, lsu_req, mdu_req, win_req;

  assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
  assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};
  assign mdu_req = '{valid: mdu_valid, rd: mdu_rd, data: mdu_data};

  logic             rr_d, rr_q;
  logic [CNT_W-1:0] wait_lsu, wait_mdu;
  logic             lsu_starved, mdu_starved;
  logic             hs;
  wb_src_e          sel;

  starve_counter #(
    .LIMIT(STARVE_LIMIT),
    .CNT_W(CNT_W)
  ) u_lsu_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .valid_i  (lsu_valid),
    .ready_i  (lsu_ready),
    .count_o  (wait_lsu),
    .starved_o(lsu_starved)
  );

  starve_counter #(
    .LIMIT(STARVE_LIMIT),
    .CNT_W(CNT_W)
  ) u_mdu_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .valid_i  (mdu_valid),
    .ready_i  (mdu_ready),
    .count_o  (wait_mdu),
    .starved_o(mdu_starved)
  );

  // Winner selection; everything is held off while reset is asserted.
  always_comb begin
    sel = WB_ALU;
    hs  = 1'b0;
    if (rst) begin
      hs = 1'b1;
      if (lsu_starved && lsu_valid && mdu_starved && mdu_valid) begin
        sel = rr_q ? WB_MDU : WB_LSU;
      end else if (lsu_starved && lsu_valid) begin
        sel = WB_LSU;
      end else if (mdu_starved && mdu_valid) begin
        sel = WB_MDU;
      end else if (alu_valid) begin
        sel = WB_ALU;
      end else if (lsu_valid && mdu_valid) begin
        sel = rr_q ? WB_MDU : WB_LSU;
      end else if (lsu_valid) begin
        sel = WB_LSU;
      end else if (mdu_valid) begin
        sel = WB_MDU;
      end else begin
        hs = 1'b0;
      end
    end
  end

  assign alu_ready = hs && (sel == WB_ALU);
  assign lsu_ready = hs && (sel == WB_LSU);
  assign mdu_ready = hs && (sel == WB_MDU);

  always_comb begin
    win_req = alu_req;
    unique case (sel)
      WB_LSU:  win_req = lsu_req;
      WB_MDU:  win_req = mdu_req;
      default: win_req = alu_req;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (lsu_ready) rr_d = 1'b1;
    if (mdu_ready) rr_d = 1'b0;
  end

  logic                  w_ena_d, w_ena_q;
  logic [4:0]            w_addr_d, w_addr_q;
  logic [DATA_WIDTH-1:0] w_data_d, w_data_q;
  logic [2:0]            grant_d, grant_q;

  always_comb begin
    w_ena_d  = 1'b0;
    w_addr_d = '0;
    w_data_d = '0;
    grant_d  = '0;
    if (hs) begin
      w_ena_d  = (win_req.rd != 5'd0);
      w_addr_d = win_req.rd;
      w_data_d = win_req.data;
      grant_d  = src_onehot(sel);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q     <= 1'b0;
      w_ena_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      grant_q  <= '0;
    end else begin
      rr_q     <= rr_d;
      w_ena_q  <= w_ena_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      grant_q  <= grant_d;
    end
  end

  // Counters must never run past the starvation limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (32'(wait_lsu) <= STARVE_LIMIT && 32'(wait_mdu) <= STARVE_LIMIT);
    end
  end

  assign w_ena   = w_ena_q;
  assign w_addr  = w_addr_q;
  assign w_data  = w_data_q;
  assign grant_o = grant_q;

endmodule
